ks_delay_line: RTL and testbench

KS_DELAY_LINE -- requirements
Module: ks_delay_line

---
 rtl/ks_delay_line.sv | 157 +++++++++++++++
 tb/tb_ks_delay_line.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_delay_line.sv
// Karplus-Strong delay line: noise fill on pluck, then recirculates filter feedback.
// Optional auto-mute after SUSTAIN loop periods: define KS_AUTOMUTE_EN.
module ks_delay_line #(
   parameter int W       = 8,
   parameter int DEPTH   = 256,
   parameter int SUSTAIN = 64
) (
   input  logic         clok,
   input  logic         rst,
   input  logic         tick,
   input  logic         pluck,
   input  logic [7:0]   len,
   input  logic [W-1:0] fb_in,
   output logic [W-1:0] ot,
   output logic         ot_valid,
   output logic         busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [AW-1:0]  r_ptr;
   logic [LW-1:0]  r_len_q;
   logic [7:0]     r_lfsr;
   logic [W-1:0]   r_mem [DEPTH];

   logic [LW-1:0]  w_len_clamp;
   logic [7:0]     w_lfsr_nxt;
   logic [W-1:0]   w_noise;
   logic           w_last;
   logic           w_fill;
   logic           w_pluck_ok;
   logic           w_tick_ok;
   logic           w_mute;

   assign w_fill     = (r_state == S_FILL);
   assign w_pluck_ok = pluck && (r_state != S_FILL);
   assign w_tick_ok  = tick && !pluck && (r_state == S_RUN);
   assign w_last     = (LW'(r_ptr) == (r_len_q - LW'(1)));
   assign w_lfsr_nxt = {r_lfsr[6:0],
                        r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_noise    = W'(r_lfsr);
   assign busy       = (r_state != S_IDLE);

   // Loop length clamped into [2, DEPTH]
   always_comb begin
      w_len_clamp = LW'(len);
      if (len < 8'd2) begin
         w_len_clamp = LW'(2);
      end else if (32'(len) > DEPTH) begin
         w_len_clamp = LW'(DEPTH);
      end
   end

`ifdef KS_AUTOMUTE_EN
   localparam int CW = $clog2(SUSTAIN + 1);

   logic [CW-1:0] r_wraps;

   assign w_mute = w_tick_ok && w_last && (r_wraps == CW'(SUSTAIN - 1));

   // Count loop wraps since the last pluck
   always_ff @(posedge clok or posedge rst) begin
      if (rst) begin
         r_wraps <= '0;
      end else if (w_pluck_ok) begin
         r_wraps <= '0;
      end else if (w_tick_ok && w_last) begin
         r_wraps <= w_mute ? '0 : r_wraps + CW'(1);
      end
   end
`else
   logic w_sustain_unused;

   assign w_mute           = 1'b0;
   assign w_sustain_unused = (SUSTAIN > 0);
`endif

   // State register
   always_ff @(posedge clok or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; pluck in FILL is ignored, pluck in RUN restarts
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (pluck) begin
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            if (w_last) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (pluck) begin
               w_state_nxt = S_FILL;
            end else if (w_mute) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Pointer, length latch, noise generator and output register
   always_ff @(posedge clok or posedge rst) begin
      if (rst) begin
         r_ptr    <= '0;
         r_len_q  <= LW'(2);
         r_lfsr   <= 8'hA5;
         ot       <= '0;
         ot_valid <= 1'b0;
      end else begin
         ot_valid <= 1'b0;
         if (w_pluck_ok) begin
            r_len_q <= w_len_clamp;
            r_ptr   <= '0;
            ot      <= '0;
         end else if (w_fill) begin
            r_lfsr <= w_lfsr_nxt;
            r_ptr  <= w_last ? '0 : r_ptr + AW'(1);
         end else if (w_tick_ok) begin
            ot       <= w_mute ? '0 : r_mem[r_ptr];
            ot_valid <= 1'b1;
            r_ptr    <= w_last ? '0 : r_ptr + AW'(1);
         end
      end
   end

   // Sample storage: noise during FILL, feedback on each RUN tick
   always_ff @(posedge clok) begin
      if (w_fill) begin
         r_mem[r_ptr] <= w_noise;
      end else if (w_tick_ok) begin
         r_mem[r_ptr] <= fb_in;
      end
   end

endmodule

// File: tb/tb_ks_delay_line.sv
// Directed bench for ks_delay_line: vector table plus corner-case sequences.
// dut/dut2 differ in DEPTH; dut3 uses a short SUSTAIN for the auto-mute case.
module tb_ks_delay_line;

   logic       clok  = 1'b0;
   logic       rst   = 1'b1;
   logic       tick  = 1'b0;
   logic       pluck = 1'b0;
   logic [7:0] len   = 8'd0;
   logic [7:0] fb_in = 8'd0;

   logic [7:0] ot1, ot2, ot3;
   logic       ov1, ov2, ov3;
   logic       bz1, bz2, bz3;

   int checks = 0;
   int errors = 0;

   always #5 clok = ~clok;

   ks_delay_line #(.W(8), .DEPTH(256), .SUSTAIN(1000000)) dut (
      .clok(clok), .rst(rst), .tick(tick), .pluck(pluck), .len(len),
      .fb_in(fb_in), .ot(ot1), .ot_valid(ov1), .busy(bz1)
   );

   ks_delay_line #(.W(8), .DEPTH(128), .SUSTAIN(1000000)) dut2 (
      .clok(clok), .rst(rst), .tick(tick), .pluck(pluck), .len(len),
      .fb_in(fb_in), .ot(ot2), .ot_valid(ov2), .busy(bz2)
   );

   ks_delay_line #(.W(8), .DEPTH(256), .SUSTAIN(3)) dut3 (
      .clok(clok), .rst(rst), .tick(tick), .pluck(pluck), .len(len),
      .fb_in(fb_in), .ot(ot3), .ot_valid(ov3), .busy(bz3)
   );

   typedef struct {
      logic       pl;
      logic       tk;
      logic [7:0] ln;
      logic [7:0] fb;
      logic       ev;
      logic [7:0] eo;
      logic       eb;
   } vec_t;

   vec_t       tv [19];
   logic [7:0] noise [10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clok);
      #1;
   endtask

   // Tick every clock after a pluck edge; n = clocks until first ot_valid
   task automatic fill_meas(input int inj, output int n);
      n = -1;
      tick = 1'b1;
      for (int i = 1; i <= 400; i++) begin
         pluck = (i == inj);
         cyc();
         if (ov1) begin
            n = i;
            break;
         end
      end
      pluck = 1'b0;
   endtask

   // Inject a marker into the loop and count ticks until it comes back
   task automatic period(output int p1, output int p2);
      tick  = 1'b1;
      fb_in = 8'h00;
      repeat (600) cyc();
      fb_in = 8'hEE;
      cyc();
      fb_in = 8'h00;
      p1 = -1;
      p2 = -1;
      for (int i = 1; i <= 300; i++) begin
         cyc();
         if (p1 < 0 && ot1 == 8'hEE) p1 = i;
         if (p2 < 0 && ot2 == 8'hEE) p2 = i;
      end
      tick = 1'b0;
   endtask

   initial begin
      int n;
      int p1;
      int p2;

      noise[0] = 8'hA5; noise[1] = 8'h4A; noise[2] = 8'h95;
      noise[3] = 8'h2A; noise[4] = 8'h54; noise[5] = 8'hA9;
      noise[6] = 8'h53; noise[7] = 8'hA7; noise[8] = 8'h4E;
      noise[9] = 8'h9D;

      tv[0]  = '{1'b1, 1'b0, 8'd5, 8'h00, 1'b0, 8'h00, 1'b1};
      tv[1]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b0, 8'h00, 1'b1};
      tv[2]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b0, 8'h00, 1'b1};
      tv[3]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b0, 8'h00, 1'b1};
      tv[4]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b0, 8'h00, 1'b1};
      tv[5]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b0, 8'h00, 1'b1};
      tv[6]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b1, 8'hA5, 1'b1};
      tv[7]  = '{1'b0, 1'b0, 8'd5, 8'h10, 1'b0, 8'hA5, 1'b1};
      tv[8]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b1, 8'h4A, 1'b1};
      tv[9]  = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b1, 8'h95, 1'b1};
      tv[10] = '{1'b0, 1'b0, 8'd5, 8'h10, 1'b0, 8'h95, 1'b1};
      tv[11] = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b1, 8'h2A, 1'b1};
      tv[12] = '{1'b0, 1'b1, 8'd5, 8'h10, 1'b1, 8'h54, 1'b1};
      tv[13] = '{1'b0, 1'b1, 8'd5, 8'h21, 1'b1, 8'h10, 1'b1};
      tv[14] = '{1'b0, 1'b1, 8'd5, 8'h21, 1'b1, 8'h10, 1'b1};
      tv[15] = '{1'b0, 1'b1, 8'd5, 8'h21, 1'b1, 8'h10, 1'b1};
      tv[16] = '{1'b0, 1'b1, 8'd5, 8'h21, 1'b1, 8'h10, 1'b1};
      tv[17] = '{1'b0, 1'b1, 8'd5, 8'h21, 1'b1, 8'h10, 1'b1};
      tv[18] = '{1'b0, 1'b1, 8'd5, 8'h21, 1'b1, 8'h21, 1'b1};

      // Reset state
      cyc();
      cyc();
      chk("rst_ot", 32'(ot1), 32'h0);
      chk("rst_valid", 32'(ov1), 32'h0);
      chk("rst_busy", 32'(bz1), 32'h0);
      chk("rst_busy2", 32'(bz2), 32'h0);
      rst = 1'b0;

      // Fill with len=5, then recirculate feedback
      for (int i = 0; i < 19; i++) begin
         pluck = tv[i].pl;
         tick  = tv[i].tk;
         len   = tv[i].ln;
         fb_in = tv[i].fb;
         cyc();
         chk($sformatf("vec%0d_valid", i), 32'(ov1), 32'(tv[i].ev));
         chk($sformatf("vec%0d_ot", i), 32'(ot1), 32'(tv[i].eo));
         chk($sformatf("vec%0d_busy", i), 32'(bz1), 32'(tv[i].eb));
      end
      pluck = 1'b0;
      tick  = 1'b0;

      // Pluck and tick together in RUN: tick dropped, FILL restarts
      pluck = 1'b1;
      tick  = 1'b1;
      cyc();
      chk("pt_valid", 32'(ov1), 32'h0);
      chk("pt_busy", 32'(bz1), 32'h1);
      chk("pt_ot", 32'(ot1), 32'h0);
      len = 8'd9;
      fill_meas(2, n);
      chk("fill_pluck_ignored", 32'(n), 32'd6);
      tick = 1'b0;

      // len=0 and len=1 clamp to 2
      len   = 8'd0;
      pluck = 1'b1;
      cyc();
      pluck = 1'b0;
      fill_meas(0, n);
      chk("fill_len0", 32'(n), 32'd3);
      period(p1, p2);
      chk("period_len0", 32'(p1), 32'd2);
      len   = 8'd1;
      pluck = 1'b1;
      cyc();
      pluck = 1'b0;
      fill_meas(0, n);
      chk("fill_len1", 32'(n), 32'd3);
      period(p1, p2);
      chk("period_len1", 32'(p1), 32'd2);
      chk("period_len1_d128", 32'(p2), 32'd2);

      // len=255: full length at DEPTH=256, clamped at DEPTH=128
      len   = 8'd255;
      pluck = 1'b1;
      cyc();
      pluck = 1'b0;
      period(p1, p2);
      chk("period_len255_d256", 32'(p1), 32'd255);
      chk("period_len255_d128", 32'(p2), 32'd128);

      // Asynchronous reset on the third FILL clock
      tick  = 1'b0;
      len   = 8'd10;
      pluck = 1'b1;
      cyc();
      pluck = 1'b0;
      cyc();
      cyc();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bz1), 32'h0);
      chk("arst_ot", 32'(ot1), 32'h0);
      chk("arst_valid", 32'(ov1), 32'h0);
      cyc();
      rst   = 1'b0;
      pluck = 1'b1;
      cyc();
      pluck = 1'b0;
      fb_in = 8'h00;
      fill_meas(0, n);
      chk("refill_len10", 32'(n), 32'd11);
      chk("refill_w0", 32'(ot1), 32'(noise[0]));
      for (int k = 1; k < 10; k++) begin
         cyc();
         chk($sformatf("refill_w%0d", k), 32'(ot1), 32'(noise[k]));
      end
      tick = 1'b0;

      // Auto-mute after SUSTAIN periods, or free-running without it
      len   = 8'd4;
      pluck = 1'b1;
      cyc();
      pluck = 1'b0;
      tick  = 1'b1;
      repeat (16) cyc();
`ifdef KS_AUTOMUTE_EN
      chk("mute_busy", 32'(bz3), 32'h0);
      chk("mute_ot", 32'(ot3), 32'h0);
`else
      repeat (88) cyc();
      chk("tick100_valid", 32'(ov3), 32'h1);
      chk("tick100_busy", 32'(bz3), 32'h1);
`endif
      tick = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
